// File: rtl/avalon_mm_slave_mem.sv
// Avalon-MM responder memory: pipelined burst writes/reads into an on-chip word array, fixed read latency.
// Optional WAITREQ_INJECT_EN adds LFSR-driven random waitrequest to stress master backpressure.
module avalon_mm_slave_mem #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 64,
  parameter int BURST_COUNT_WIDTH = 8,
  parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_WORDS         = 1024,
  parameter int READ_LATENCY      = 2,
  parameter int MAX_PENDING       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [BURST_COUNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH-1:0]        writedata,
  input  logic [BYTE_ENABLE_WIDTH-1:0] byteenable,
  input  logic                         write,
  input  logic                         read,
  output logic                         waitrequest,
  output logic [DATA_WIDTH-1:0]        readdata,
  output logic                         readdatavalid
);

  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam int BE_SHIFT = $clog2(BYTE_ENABLE_WIDTH);
  localparam int PTR_W    = $clog2(MAX_PENDING);
  localparam int OCC_W    = PTR_W + 1;

  localparam logic [BURST_COUNT_WIDTH-1:0] BC_ONE   = BURST_COUNT_WIDTH'(1);
  localparam logic [IDX_W-1:0]             IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_W-1:0]             PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0]             OCC_FULL = OCC_W'(MAX_PENDING);

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_BURST = 1'b1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                         rst_hold;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [IDX_W-1:0]             addr_idx;
  logic [BURST_COUNT_WIDTH-1:0] bc_eff;
  logic                         wr_accept;
  logic                         rd_accept;
  logic                         unused_addr;

  assign addr_idx    = address[BE_SHIFT +: IDX_W];
  assign bc_eff      = (burstcount == '0) ? BC_ONE : burstcount;
  assign unused_addr = ^address;

  always_ff @(posedge clk) begin
    rst_hold <= rst;
  end

`ifdef WAITREQ_INJECT_EN
  logic [15:0] lfsr;

  // Taps 16,14,13,11 in right-shift Fibonacci form
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign waitrequest = rst_hold | fifo_full | (lfsr[1:0] == 2'b00);
`else
  assign waitrequest = rst_hold | fifo_full;
`endif

  // ---- write burst tracking; wr_left = beats still owed after the one just taken
  logic                         wr_active;
  logic [IDX_W-1:0]             wr_idx;
  logic [IDX_W-1:0]             wr_beat_idx;
  logic [BURST_COUNT_WIDTH-1:0] wr_left;

  assign wr_accept   = write & ~waitrequest;
  assign rd_accept   = read & ~write & ~wr_active & ~waitrequest;
  assign wr_beat_idx = wr_active ? wr_idx : addr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_active <= 1'b0;
      wr_idx    <= '0;
      wr_left   <= '0;
    end else if (wr_accept) begin
      if (wr_active) begin
        wr_active <= (wr_left != BC_ONE);
        wr_idx    <= wr_idx + IDX_ONE;
        wr_left   <= wr_left - BC_ONE;
      end else begin
        wr_active <= (bc_eff != BC_ONE);
        wr_idx    <= addr_idx + IDX_ONE;
        wr_left   <= bc_eff - BC_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < BYTE_ENABLE_WIDTH; b++) begin
        if (byteenable[b]) mem[wr_beat_idx][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // ---- read command FIFO
  logic [IDX_W-1:0]             fifo_idx [MAX_PENDING];
  logic [BURST_COUNT_WIDTH-1:0] fifo_cnt [MAX_PENDING];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [OCC_W-1:0]             occ;
  logic                         pop;
  logic [IDX_W-1:0]             head_idx;
  logic [BURST_COUNT_WIDTH-1:0] head_cnt;

  assign fifo_full  = (occ == OCC_FULL);
  assign fifo_empty = (occ == '0);
  assign head_idx   = fifo_idx[rd_ptr];
  assign head_cnt   = fifo_cnt[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (rd_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)       rd_ptr <= rd_ptr + PTR_ONE;
      occ <= occ + OCC_W'(rd_accept) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      fifo_idx[wr_ptr] <= addr_idx;
      fifo_cnt[wr_ptr] <= bc_eff;
    end
  end

  // ---- read engine; eng_left counts beats still to issue including eng_idx
  logic [0:0]                   rd_state;
  logic [0:0]                   rd_state_n;
  logic [IDX_W-1:0]             eng_idx;
  logic [IDX_W-1:0]             eng_idx_n;
  logic [BURST_COUNT_WIDTH-1:0] eng_left;
  logic [BURST_COUNT_WIDTH-1:0] eng_left_n;
  logic                         issue;
  logic [IDX_W-1:0]             issue_idx;

  always_comb begin
    pop        = 1'b0;
    issue      = 1'b0;
    issue_idx  = head_idx;
    rd_state_n = rd_state;
    eng_idx_n  = eng_idx;
    eng_left_n = eng_left;
    if (rd_state == RD_IDLE) begin
      if (!fifo_empty) begin
        pop   = 1'b1;
        issue = 1'b1;
        if (head_cnt != BC_ONE) begin
          rd_state_n = RD_BURST;
          eng_idx_n  = head_idx + IDX_ONE;
          eng_left_n = head_cnt - BC_ONE;
        end
      end
    end else begin
      issue     = 1'b1;
      issue_idx = eng_idx;
      if (eng_left != BC_ONE) begin
        eng_idx_n  = eng_idx + IDX_ONE;
        eng_left_n = eng_left - BC_ONE;
      end else if (!fifo_empty) begin
        // Chain straight into the next command so bursts stay back to back
        pop        = 1'b1;
        eng_idx_n  = head_idx;
        eng_left_n = head_cnt;
      end else begin
        rd_state_n = RD_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      eng_idx  <= '0;
      eng_left <= '0;
    end else begin
      rd_state <= rd_state_n;
      eng_idx  <= eng_idx_n;
      eng_left <= eng_left_n;
    end
  end

  // ---- stage p0: array read; stages p1..: latency delay line
  logic [DATA_WIDTH-1:0]   rdata_p [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rdata_p[0] <= mem[issue_idx];
    for (int i = 1; i < READ_LATENCY; i++) rdata_p[i] <= rdata_p[i-1];
  end

  assign readdatavalid = vld_p[READ_LATENCY-1];
  assign readdata      = vld_p[READ_LATENCY-1] ? rdata_p[READ_LATENCY-1] : '0;

`ifndef SYNTHESIS
  // A read alongside a write, or inside an open write burst, is a master protocol error
  assert property (@(posedge clk) disable iff (rst) !(read && (write || wr_active)));
`endif

endmodule

// File: tb/tb_avalon_mm_slave_mem.sv
// Self-checking bench for avalon_mm_slave_mem: directed scenarios plus randomized bursts
// checked against a word-array reference model with byte-lane merging and index wrap.
module tb_avalon_mm_slave_mem;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int BCW   = 8;
  localparam int BEW   = DW / 8;
  localparam int WORDS = 1024;
  localparam int LAT   = 2;
  localparam int PEND  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  address;
  logic [BCW-1:0] burstcount;
  logic [DW-1:0]  writedata;
  logic [BEW-1:0] byteenable;
  logic           write;
  logic           read;
  logic           waitrequest;
  logic [DW-1:0]  readdata;
  logic           readdatavalid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] wbuf [256];
  logic [DW-1:0] got_data [$];
  int            got_cyc [$];

  avalon_mm_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_COUNT_WIDTH(BCW), .BYTE_ENABLE_WIDTH(BEW),
    .MEM_WORDS(WORDS), .READ_LATENCY(LAT), .MAX_PENDING(PEND)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .burstcount(burstcount),
    .writedata(writedata), .byteenable(byteenable), .write(write), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Beats are tagged with the number of the edge that made them visible
  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      got_data.push_back(readdata);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (waitrequest !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    ok = (waitrequest === 1'b0);
  endtask

  // Later beats carry junk address/burstcount, which the slave must ignore
  task automatic wr_burst(input int idx, input int n, input logic [BEW-1:0] be,
                          input logic [BCW-1:0] bc_field);
    bit ok;
    for (int k = 0; k < n; k++) begin
      address    = (k == 0) ? AW'(idx * BEW) : AW'($urandom);
      burstcount = (k == 0) ? bc_field : BCW'($urandom);
      writedata  = wbuf[k];
      byteenable = be;
      write      = 1'b1;
      wait_ready(ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL wr_ready: waitrequest=%b want 0", waitrequest);
      end
      tick();
      for (int b = 0; b < BEW; b++)
        if (be[b]) ref_mem[(idx + k) % WORDS][b*8 +: 8] = wbuf[k][b*8 +: 8];
    end
    write      = 1'b0;
    byteenable = '0;
  endtask

  task automatic rd_cmd(input int idx, input logic [BCW-1:0] bc, output int t0);
    bit ok;
    address    = AW'(idx * BEW);
    burstcount = bc;
    read       = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rd_ready: waitrequest=%b want 0", waitrequest);
    end
    tick();
    t0   = cyc;
    read = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int g = 0;
    while (got_data.size() < n && g < 2000) begin
      tick();
      g++;
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; write = 1'b0; read = 1'b0; address = '0; burstcount = '0;
    writedata = '0; byteenable = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    repeat (3) tick();
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait: got %b want 1", waitrequest); end
    checks++;
    if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", readdatavalid); end
    checks++;
    if (readdata !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", readdata); end
    rst = 1'b0;
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b want 1", waitrequest); end
    tick();
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_release: got %b want 0", waitrequest); end
  endtask

  task automatic test_single_rw();
    int t0;
    wbuf[0] = 64'h0000_0000_DEAD_BEEF;
    wr_burst(8, 1, 8'hFF, 8'd1);
    got_data.delete(); got_cyc.delete();
    rd_cmd(8, 8'd1, t0);
    wait_beats(1);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 64'h0000_0000_DEAD_BEEF) begin
        errors++; $display("FAIL single_data: got %h want 00000000deadbeef", got_data[0]);
      end
      checks++;
      if (got_cyc[0] != t0 + LAT) begin
        errors++; $display("FAIL single_latency: got edge %0d want %0d", got_cyc[0], t0 + LAT);
      end
    end
  endtask

  task automatic test_byteenable();
    int t0;
    wbuf[0] = 64'hFFFF_FFFF_0000_0000;
    wr_burst(8, 1, 8'hF0, 8'd1);
    got_data.delete(); got_cyc.delete();
    rd_cmd(8, 8'd1, t0);
    wait_beats(1);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL be_count: got %0d want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 64'hFFFF_FFFF_DEAD_BEEF) begin
        errors++; $display("FAIL be_data: got %h want ffffffffdeadbeef", got_data[0]);
      end
    end
  endtask

  task automatic test_burst();
    int t0;
    for (int k = 0; k < 8; k++) wbuf[k] = DW'(k);
    wr_burst(32, 8, 8'hFF, 8'd8);
    got_data.delete(); got_cyc.delete();
    rd_cmd(32, 8'd8, t0);
    wait_beats(8);
    checks++;
    if (got_data.size() != 8) begin
      errors++; $display("FAIL burst_count: got %0d want 8", got_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got_data[k] !== DW'(k) || got_cyc[k] != t0 + LAT + k) begin
          errors++;
          $display("FAIL burst_beat%0d: got %h@%0d want %h@%0d", k, got_data[k], got_cyc[k], k, t0 + LAT + k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int starts [5];
    int t0, tx;
    logic [DW-1:0] exp_q [$];
    for (int c = 0; c < 5; c++) begin
      starts[c] = 100 + 16 * c + $urandom_range(0, 8);
      for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
      wr_burst(starts[c], 4, 8'hFF, 8'd4);
    end
    for (int c = 0; c < 5; c++)
      for (int k = 0; k < 4; k++) exp_q.push_back(ref_mem[starts[c] + k]);
    got_data.delete(); got_cyc.delete();
    rd_cmd(starts[0], 8'd4, t0);
    for (int c = 1; c < 5; c++) rd_cmd(starts[c], 8'd4, tx);
    wait_beats(20);
    checks++;
    if (got_data.size() != 20) begin
      errors++; $display("FAIL b2b_count: got %0d want 20", got_data.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (got_data[k] !== exp_q[k] || got_cyc[k] != t0 + LAT + k) begin
          errors++;
          $display("FAIL b2b_beat%0d: got %h@%0d want %h@%0d", k, got_data[k], got_cyc[k], exp_q[k], t0 + LAT + k);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int t0, tx;
    bit saw_wait = 1'b0;
    for (int k = 0; k < 64; k++) wbuf[k] = {$urandom, $urandom};
    wr_burst(512, 64, 8'hFF, 8'd64);
    got_data.delete(); got_cyc.delete();
    rd_cmd(512, 8'd8, t0);
    for (int c = 1; c < 8; c++) begin
      rd_cmd(512 + 8 * c, 8'd8, tx);
      if (waitrequest === 1'b1) saw_wait = 1'b1;
    end
    checks++;
    if (!saw_wait) begin errors++; $display("FAIL full_wait: got waitrequest never high want high once queue fills"); end
    wait_beats(64);
    checks++;
    if (got_data.size() != 64) begin
      errors++; $display("FAIL full_count: got %0d want 64", got_data.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (got_data[k] !== ref_mem[512 + k] || got_cyc[k] != t0 + LAT + k) begin
          errors++;
          $display("FAIL full_beat%0d: got %h@%0d want %h@%0d", k, got_data[k], got_cyc[k], ref_mem[512 + k], t0 + LAT + k);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int t0;
    wbuf[0] = {$urandom, $urandom};
    wbuf[1] = {$urandom, $urandom};
    wr_burst(WORDS - 1, 2, 8'hFF, 8'd2);
    got_data.delete(); got_cyc.delete();
    rd_cmd(WORDS - 1, 8'd2, t0);
    wait_beats(2);
    rd_cmd(0, 8'd1, t0);
    wait_beats(3);
    checks++;
    if (got_data.size() != 3) begin
      errors++; $display("FAIL wrap_count: got %0d want 3", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== wbuf[0]) begin errors++; $display("FAIL wrap_last: got %h want %h", got_data[0], wbuf[0]); end
      checks++;
      if (got_data[1] !== wbuf[1]) begin errors++; $display("FAIL wrap_next: got %h want %h", got_data[1], wbuf[1]); end
      checks++;
      if (got_data[2] !== wbuf[1]) begin errors++; $display("FAIL wrap_word0: got %h want %h", got_data[2], wbuf[1]); end
    end
  endtask

  task automatic test_bc_zero();
    int t0;
    wbuf[0] = {$urandom, $urandom};
    wr_burst(700, 1, 8'hFF, 8'd0);
    wbuf[0] = {$urandom, $urandom};
    wr_burst(900, 1, 8'hFF, 8'd1);
    got_data.delete(); got_cyc.delete();
    rd_cmd(700, 8'd0, t0);
    wait_beats(1);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL bc0_count: got %0d want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== ref_mem[700]) begin errors++; $display("FAIL bc0_data: got %h want %h", got_data[0], ref_mem[700]); end
    end
    got_data.delete(); got_cyc.delete();
    rd_cmd(900, 8'd1, t0);
    wait_beats(1);
    checks++;
    if (got_data.size() != 1 || got_data[0] !== ref_mem[900]) begin
      errors++; $display("FAIL bc0_next: got %0d beats %h want 1 beat %h", got_data.size(),
                         (got_data.size() > 0) ? got_data[0] : '0, ref_mem[900]);
    end
  endtask

  task automatic test_random();
    int idx [6];
    int len [6];
    int t0, n;
    for (int r = 0; r < 6; r++) begin
      idx[r] = $urandom_range(0, WORDS - 1);
      len[r] = $urandom_range(1, 6);
      for (int k = 0; k < len[r]; k++) wbuf[k] = {$urandom, $urandom};
      wr_burst(idx[r], len[r], 8'hFF, BCW'(len[r]));
      for (int k = 0; k < len[r]; k++) wbuf[k] = {$urandom, $urandom};
      wr_burst(idx[r], len[r], BEW'($urandom_range(1, 255)), BCW'(len[r]));
    end
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, len[r]);
      got_data.delete(); got_cyc.delete();
      rd_cmd(idx[r], BCW'(n), t0);
      wait_beats(n);
      checks++;
      if (got_data.size() != n) begin
        errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, got_data.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (got_data[k] !== ref_mem[(idx[r] + k) % WORDS]) begin
            errors++;
            $display("FAIL rand%0d_beat%0d: got %h want %h", r, k, got_data[k], ref_mem[(idx[r] + k) % WORDS]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int t0, g, n_before;
    got_data.delete(); got_cyc.delete();
    rd_cmd(32, 8'd8, t0);
    g = 0;
    while (got_data.size() < 3 && g < 50) begin tick(); g++; end
    checks++;
    if (got_data.size() < 3) begin errors++; $display("FAIL midrst_start: got %0d beats want 3", got_data.size()); end
    rst = 1'b1;
    tick();
    checks++;
    if (readdatavalid !== 1'b0 || readdata !== '0) begin
      errors++; $display("FAIL midrst_valid: got %b/%h want 0/0", readdatavalid, readdata);
    end
    n_before = got_data.size();
    rst = 1'b0;
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL midrst_hold: got %b want 1", waitrequest); end
    tick();
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL midrst_release: got %b want 0", waitrequest); end
    repeat (10) tick();
    checks++;
    if (got_data.size() != n_before) begin
      errors++; $display("FAIL midrst_drop: got %0d beats want %0d", got_data.size(), n_before);
    end
    got_data.delete(); got_cyc.delete();
    rd_cmd(32, 8'd8, t0);
    wait_beats(8);
    checks++;
    if (got_data.size() != 8) begin
      errors++; $display("FAIL midrst_rb_count: got %0d want 8", got_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got_data[k] !== ref_mem[32 + k]) begin
          errors++; $display("FAIL midrst_rb%0d: got %h want %h", k, got_data[k], ref_mem[32 + k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_byteenable();
    test_burst();
    test_back_to_back();
    test_fifo_full();
    test_wrap();
    test_bc_zero();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
